// File: rtl/ram_sp_clr_pkg.sv
// rtl/ram_sp_clr_pkg.sv - shared types and constants for the clearable single-port RAM
package ram_pkg;

  typedef enum logic {
    ST_CLEAR,
    ST_IDLE
  } state_t;

  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF  = 16384;

  function automatic int lanes(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/ram_sp_clr_if.sv
// rtl/ram_sp_clr_if.sv - request/response bus between a bus master and ram_sp_clr
interface ram_sp_clr_if
  import ram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = $clog2(DEPTH_DEF)
);

  logic                        req_valid;
  logic                        req_ready;
  logic                        req_we;
  logic [ADDR_W-1:0]           req_addr;
  logic [DATA_W-1:0]           req_wdata;
  logic [lanes(DATA_W)-1:0]    req_be;
  logic                        rsp_valid;
  logic [DATA_W-1:0]           rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/ram_sp_core.sv
// rtl/ram_sp_core.sv - bare storage array with byte-lane writes and registered read
module ram_sp_core
  import ram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [lanes(DATA_W)-1:0] be,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);

  localparam int LANES = lanes(DATA_W);

  // No reset on the array or read register so the tools map this onto block RAM.
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < LANES; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/ram_sp_clr.sv
// rtl/ram_sp_clr.sv - single-port RAM with clear engine; RAM_SP_CLR_OUTREG_EN adds an output stage
module ram_sp_clr
  import ram_pkg::*;
#(
  parameter int                DATA_W  = DATA_W_DEF,
  parameter int                DEPTH   = DEPTH_DEF,
  parameter int                ADDR_W  = $clog2(DEPTH),
  parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr_start,
  output logic       busy,
  ram_sp_clr_if.slave bus
);

  localparam int                LANES   = lanes(DATA_W);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_CLEAR: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == LAST) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
      end
      ST_IDLE: begin
        if (clr_start) begin
          state_nxt = ST_CLEAR;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = ST_CLEAR;
    endcase
  end

  assign busy          = (state == ST_CLEAR);
  assign bus.req_ready = (state == ST_IDLE);

  logic accept, in_range, rd_fire;
  assign accept   = bus.req_valid & bus.req_ready;
  assign in_range = ({1'b0, bus.req_addr} < DEPTH_X);
  assign rd_fire  = accept & ~bus.req_we;

  // The clear engine owns the single port whenever it runs; requests are never accepted then.
  logic                 core_en, core_we;
  logic [LANES-1:0]     core_be;
  logic [ADDR_W-1:0]    core_addr;
  logic [DATA_W-1:0]    core_wdata, core_rdata;

  assign core_en    = busy | (accept & in_range);
  assign core_we    = busy | bus.req_we;
  assign core_be    = busy ? '1      : bus.req_be;
  assign core_addr  = busy ? cnt     : bus.req_addr;
  assign core_wdata = busy ? CLR_VAL : bus.req_wdata;

  ram_sp_core #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clk   (clk),
    .en    (core_en),
    .we    (core_we),
    .be    (core_be),
    .addr  (core_addr),
    .wdata (core_wdata),
    .rdata (core_rdata)
  );

  logic              v1, oor1;
  logic [DATA_W-1:0] sel, hold;

  assign sel = oor1 ? '0 : core_rdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1   <= 1'b0;
      oor1 <= 1'b0;
      hold <= '0;
    end else begin
      v1   <= rd_fire;
      oor1 <= ~in_range;
      if (v1) hold <= sel;
    end
  end

`ifdef RAM_SP_CLR_OUTREG_EN
  // hold doubles as the second data stage; only the valid needs its own flop.
  logic v2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) v2 <= 1'b0;
    else        v2 <= v1;
  end

  assign bus.rsp_valid = v2;
  assign bus.rsp_rdata = hold;
`else
  assign bus.rsp_valid = v1;
  assign bus.rsp_rdata = v1 ? sel : hold;
`endif

endmodule

// File: tb/tb_ram_sp_clr.sv
// tb/tb_ram_sp_clr.sv - self-checking bench for ram_sp_clr at DEPTH 16384 and DEPTH 1000
module tb_ram_sp_clr;

`ifdef RAM_SP_CLR_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int D1 = 16384;
  localparam int D2 = 1000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clr_start = 1'b0;
  logic busy1, busy2;

  int checks = 0;
  int errors = 0;

  logic [15:0] mdl1 [D1];
  logic [15:0] mdl2 [D2];

  always #5 clk = ~clk;

  ram_sp_clr_if #(.DATA_W(16), .ADDR_W(14)) b1 ();
  ram_sp_clr_if #(.DATA_W(16), .ADDR_W(10)) b2 ();

  assign b2.req_valid = b1.req_valid;
  assign b2.req_we    = b1.req_we;
  assign b2.req_addr  = b1.req_addr[9:0];
  assign b2.req_wdata = b1.req_wdata;
  assign b2.req_be    = b1.req_be;

  ram_sp_clr #(.DATA_W(16), .DEPTH(D1), .ADDR_W(14), .CLR_VAL(16'h0000)) u_big (
    .clk(clk), .reset(reset), .clr_start(clr_start), .busy(busy1), .bus(b1.slave)
  );

  ram_sp_clr #(.DATA_W(16), .DEPTH(D2), .ADDR_W(10), .CLR_VAL(16'h0000)) u_small (
    .clk(clk), .reset(reset), .clr_start(clr_start), .busy(busy2), .bus(b2.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] data,
                                        input logic [1:0] be);
    logic [15:0] mask;
    mask = {{8{be[1]}}, {8{be[0]}}};
    return (old & ~mask) | (data & mask);
  endfunction

  task automatic mdl_clear();
    for (int i = 0; i < D1; i++) mdl1[i] = 16'h0000;
    for (int i = 0; i < D2; i++) mdl2[i] = 16'h0000;
  endtask

  task automatic mdl_write(input logic [13:0] addr, input logic [15:0] data, input logic [1:0] be);
    logic [9:0] a2;
    mdl1[addr] = merge(mdl1[addr], data, be);
    a2 = addr[9:0];
    if (int'(a2) < D2) mdl2[a2] = merge(mdl2[a2], data, be);
  endtask

  function automatic logic [15:0] exp2(input logic [13:0] addr);
    logic [9:0] a2;
    a2 = addr[9:0];
    return (int'(a2) < D2) ? mdl2[a2] : 16'h0000;
  endfunction

  task automatic do_write(input logic [13:0] addr, input logic [15:0] data, input logic [1:0] be);
    chk("wr_ready_big", 32'(b1.req_ready), 32'd1);
    chk("wr_ready_small", 32'(b2.req_ready), 32'd1);
    b1.req_valid = 1'b1;
    b1.req_we    = 1'b1;
    b1.req_addr  = addr;
    b1.req_wdata = data;
    b1.req_be    = be;
    tick();
    b1.req_valid = 1'b0;
    mdl_write(addr, data, be);
  endtask

  task automatic do_read(input logic [13:0] addr);
    logic [15:0] e1, e2;
    int lat;
    e1 = mdl1[addr];
    e2 = exp2(addr);
    b1.req_valid = 1'b1;
    b1.req_we    = 1'b0;
    b1.req_addr  = addr;
    b1.req_wdata = 16'($urandom);
    b1.req_be    = 2'($urandom);
    tick();
    b1.req_valid = 1'b0;
    lat = 1;
    while (!b1.rsp_valid && lat < 4) begin
      tick();
      lat++;
    end
    chk("rd_latency", 32'(lat), 32'(LAT));
    chk("rd_data_big", 32'(b1.rsp_rdata), 32'(e1));
    chk("rd_valid_small", 32'(b2.rsp_valid), 32'd1);
    chk("rd_data_small", 32'(b2.rsp_rdata), 32'(e2));
    tick();
    chk("rsp_pulse", 32'(b1.rsp_valid), 32'd0);
  endtask

  // Counts edges until busy drops; optionally pulses clr_start mid-way.
  task automatic measure_clear(input int pulse_at, output int n, output int bad, output int got,
                               output logic [15:0] gdata);
    n = 0;
    bad = 0;
    got = 0;
    gdata = 16'h0000;
    do begin
      tick();
      n++;
      if (busy1 && b1.req_ready) bad++;
      if (b1.rsp_valid) begin
        got++;
        gdata = b1.rsp_rdata;
      end
      clr_start = (n == pulse_at);
    end while (busy1 && n < 20000);
    clr_start = 1'b0;
  endtask

  initial begin
    int n, bad, got;
    logic [15:0] gdata;
    logic [13:0] ra;

    b1.req_valid = 1'b0;
    b1.req_we    = 1'b0;
    b1.req_addr  = '0;
    b1.req_wdata = '0;
    b1.req_be    = '0;
    mdl_clear();

    repeat (3) tick();
    chk("rst_busy", 32'(busy1), 32'd1);
    chk("rst_ready", 32'(b1.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(b1.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", 32'(b1.rsp_rdata), 32'd0);
    chk("rst_busy_small", 32'(busy2), 32'd1);

    // A write held throughout the initial clear must wait until the clear ends.
    b1.req_valid = 1'b1;
    b1.req_we    = 1'b1;
    b1.req_addr  = 14'h0020;
    b1.req_wdata = 16'hDEAD;
    b1.req_be    = 2'b11;
    reset = 1'b1;
    measure_clear(-1, n, bad, got, gdata);
    chk("init_clear_len", 32'(n), 32'(D1));
    chk("init_no_ready", 32'(bad), 32'd0);
    chk("init_no_rsp", 32'(got), 32'd0);
    chk("ready_after_clear", 32'(b1.req_ready), 32'd1);
    chk("small_idle", 32'(busy2), 32'd0);
    tick();
    b1.req_valid = 1'b0;
    mdl_write(14'h0020, 16'hDEAD, 2'b11);

    do_read(14'h0000);
    do_read(14'h1234);
    do_read(14'h3FFF);
    do_read(14'h0020);

    do_write(14'h0100, 16'hBEEF, 2'b11);
    do_read(14'h0100);
    do_write(14'h0100, 16'h1200, 2'b10);
    do_read(14'h0100);
    do_write(14'h0100, 16'hFFFF, 2'b00);
    do_read(14'h0100);

    for (int i = 1; i <= 4; i++) do_write(14'(i), 16'(8'h11 * i), 2'b11);
    for (int t = 1; t <= 3 + LAT; t++) begin
      if (t <= 4) begin
        b1.req_valid = 1'b1;
        b1.req_we    = 1'b0;
        b1.req_addr  = 14'(t);
      end else begin
        b1.req_valid = 1'b0;
      end
      tick();
      if (t >= LAT && t - LAT < 4) begin
        chk("burst_valid", 32'(b1.rsp_valid), 32'd1);
        chk("burst_data", 32'(b1.rsp_rdata), 32'(8'h11 * (t - LAT + 1)));
        chk("burst_data_small", 32'(b2.rsp_rdata), 32'(8'h11 * (t - LAT + 1)));
      end
    end
    b1.req_valid = 1'b0;
    tick();

    do_write(14'd1005, 16'hCAFE, 2'b11);
    do_read(14'd1005);

    // Read accepted on the same edge as clr_start still returns the pre-clear word.
    do_write(14'h0010, 16'hA5A5, 2'b11);
    b1.req_valid = 1'b1;
    b1.req_we    = 1'b0;
    b1.req_addr  = 14'h0010;
    clr_start    = 1'b1;
    tick();
    b1.req_valid = 1'b0;
    clr_start    = 1'b0;
    chk("clr_busy_next", 32'(busy1), 32'd1);
    chk("clr_ready_next", 32'(b1.req_ready), 32'd0);
    got = 0;
    gdata = 16'h0000;
    if (b1.rsp_valid) begin
      got = 1;
      gdata = b1.rsp_rdata;
    end
    begin
      int n2, bad2, got2;
      logic [15:0] gd2;
      measure_clear(5000, n2, bad2, got2, gd2);
      chk("clr_len_with_pulse", 32'(n2), 32'(D1));
      chk("clr_no_ready", 32'(bad2), 32'd0);
      if (got2 != 0) gdata = gd2;
      chk("same_cycle_rsp_count", 32'(got + got2), 32'd1);
      chk("same_cycle_rsp_data", 32'(gdata), 32'hA5A5);
    end
    mdl_clear();
    repeat (1100) tick();
    do_read(14'h0010);
    do_read(14'h0100);

    // Reset in the middle of a clear.
    do_write(14'h0200, 16'h55AA, 2'b11);
    do_read(14'h0200);
    b1.req_valid = 1'b1;
    b1.req_we    = 1'b0;
    b1.req_addr  = 14'h0200;
    clr_start    = 1'b1;
    tick();
    b1.req_valid = 1'b0;
    clr_start    = 1'b0;
    repeat (3000) tick();
    reset = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy1), 32'd1);
    chk("midrst_ready", 32'(b1.req_ready), 32'd0);
    chk("midrst_rsp_valid", 32'(b1.rsp_valid), 32'd0);
    chk("midrst_rsp_rdata", 32'(b1.rsp_rdata), 32'd0);
    chk("midrst_rdata_small", 32'(b2.rsp_rdata), 32'd0);
    #2;
    reset = 1'b1;
    measure_clear(-1, n, bad, got, gdata);
    chk("restart_clear_len", 32'(n), 32'(D1));
    chk("restart_no_ready", 32'(bad), 32'd0);
    mdl_clear();
    do_read(14'h0200);

    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 3) == 0) ra = 14'($urandom_range(0, D1 - 1));
      else                           ra = 14'($urandom_range(0, 1100));
      if ($urandom_range(0, 1) == 1) do_write(ra, 16'($urandom), 2'($urandom));
      else                           do_read(ra);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_sp_clr.md
Name: ram_sp_clr

Overview:
- Parametrised single-port synchronous RAM. Successor to the fixed 16K x 16 store.
- Adds a valid/ready request handshake, byte-lane write enables and a response-valid strobe.
- Adds a sequential clear engine, so the storage array itself carries no reset and infers block RAM.
- Sits between the CPU/datapath bus and on-chip memory; usable as data RAM or scratchpad.

Parameters:
- DATA_W, 16, word width in bits; must be a multiple of 8.
- DEPTH, 16384, number of words; need not be a power of 2.
- ADDR_W, $clog2(DEPTH), address width.
- CLR_VAL, 0, DATA_W-bit value written to every word during a clear.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  access request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- req_be  in  DATA_W/8  byte-lane write enables; bit i covers bits [8i+7:8i].
- rsp_valid  out  1  one-cycle pulse: rsp_rdata holds read data.
- rsp_rdata  out  DATA_W  read data; held until the next read response.
- clr_start  in  1  pulse to start a full-memory clear.
- busy  out  1  clear in progress.

Behaviour:
- Reset (reset=0, asynchronous):
  - rsp_valid=0, rsp_rdata=0, req_ready=0, busy=1.
  - FSM forced to CLEAR with clear counter=0.
  - Memory array contents are not reset directly.
- FSM states: CLEAR, IDLE.
- CLEAR:
  - Writes CLR_VAL to address cnt each cycle, then cnt++.
  - When cnt==DEPTH-1 is written, move to IDLE on the next edge.
  - A clear takes exactly DEPTH cycles.
  - busy=1 and req_ready=0 throughout; requests are not accepted.
  - clr_start is ignored.
- After reset deassertion, the block automatically runs one full clear before the first access.
- IDLE:
  - busy=0, req_ready=1.
  - clr_start=1 moves to CLEAR with cnt=0 on the next edge. busy and req_ready change in the following cycle.
  - A request accepted in the same cycle as clr_start completes normally.
- Accept: a request is accepted on a clock edge where req_valid and req_ready are both 1.
- Write:
  - Each lane with req_be[i]=1 is updated; lanes with be=0 keep their old value.
  - req_be=0 is a no-op write.
  - No response is generated for writes.
- Read:
  - rsp_valid=1 exactly one cycle after acceptance; rsp_rdata = word at req_addr.
  - Back-to-back reads give one response per cycle at full throughput.
- Read-after-write to the same address in consecutive cycles returns the new data.
- Out-of-range address (req_addr >= DEPTH):
  - Writes are discarded.
  - Reads return 0 with rsp_valid=1.
- Reset mid-clear or mid-read: the response is dropped (rsp_valid=0) and the clear restarts from address 0.
- req_ready does not depend combinationally on req_valid.

Optional Feature:
- Macro: RAM_SP_CLR_OUTREG_EN.
- Defined:
  - Extra output register stage; read latency is 2 cycles.
  - rsp_valid and rsp_rdata are both pipelined; throughput remains 1 per cycle.
  - Reset clears both stages.
- Undefined: read latency is 1 cycle, as in Behaviour.

Decomposition:
- Package ram_pkg:
  - state typedef (ST_CLEAR, ST_IDLE).
  - Default DATA_W/DEPTH constants.
  - Function computing lane count DATA_W/8.
- Sub-module ram_sp_core:
  - Bare storage array, no reset, registered read.
  - Byte-enable write; one read or write port driven by mux from the FSM or the request.
- Top level holds the FSM, counter, handshake and response pipeline.

Test Plan:
- Reset release → busy=1 for 16384 cycles then 0. Read addr 0x0000, 0x1234 and 0x3FFF → rsp_rdata=0x0000 each, with rsp_valid 1 cycle after accept.
- Write 0xBEEF to 0x0100 with be=2'b11, then read 0x0100 → rsp_rdata=0xBEEF. Write 0x1200 with be=2'b10, then read → 0x12EF.
- During the initial clear, hold req_valid=1 → req_ready=0 and no write takes effect. After busy falls, the request is accepted on the first cycle.
- Write 0xA5A5 to 0x0010, pulse clr_start, then read 0x0010 after busy falls → 0x0000. clr_start pulsed during CLEAR → clear length stays DEPTH cycles.
- Back-to-back reads of 0x0001..0x0004 after writing 0x11..0x44 → rsp_rdata 0x11, 0x22, 0x33, 0x44 on consecutive cycles. With DEPTH=1000, read 1005 → 0.
- Assert reset midway through a clear → outputs take reset values immediately; after release the clear restarts and lasts the full DEPTH cycles. With RAM_SP_CLR_OUTREG_EN defined, read latency measures 2 cycles.
